// File: rtl/seg_reg_hs.sv
// Pipeline segment register with valid/ready handshake, flush, optional
// two-entry skid buffer, and saturating stall/flush statistics.
module seg_reg_hs #(
  parameter int                DATA_W    = 32,
  parameter int                SKID      = 1,
  parameter logic [DATA_W-1:0] CLR_VALUE = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              in_ready;
  logic              out_valid;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state_q != EMPTY);
  assign out_fire  = out_valid & out_ready_i;
  assign in_fire   = in_valid_i & in_ready & ~flush_i;

  generate
    if (SKID != 0) begin : g_skid
      // in_ready is a flop here so the upstream sees no path from out_ready.
      logic in_ready_q;
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          in_ready_q <= 1'b1;
          skid_q     <= CLR_VALUE;
        end else begin
          in_ready_q <= (state_d != TWO);
          skid_q     <= skid_d;
        end
      end
      assign in_ready = in_ready_q;
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready_i;
      assign skid_q   = CLR_VALUE;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = CLR_VALUE;
      skid_d  = CLR_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data_i;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire && (SKID != 0)) begin
            state_d = TWO;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = CLR_VALUE;
          end
        end
        TWO: begin
          // Draining the skid entry leaves it empty, so it returns to the NOP value.
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = CLR_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = CLR_VALUE;
          skid_d  = CLR_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= CLR_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (out_valid && !out_ready_i && (stall_q != CNT_MAX)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_i && (out_valid || (in_valid_i && in_ready)) && (flush_q != CNT_MAX)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign out_data_o  = main_q;
  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule
